credit_engine: RTL

//  Parametrised credit-controlled transaction engine: ap_start/ap_done handshake, one-cycle descriptor lookup {base,len},

---
 rtl/credit_engine_pkg.sv | 20 ++
 rtl/credit_engine_fifo.sv | 69 ++++++
 rtl/credit_engine.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/credit_engine_pkg.sv
// credit_engine_pkg: shared FSM state encoding and the credit-fit helper
// used by the credit-controlled transaction engine.
package credit_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_DESC,
    WAIT_DESC,
    CHECK,
    BURST,
    DRAIN,
    DONE
  } state_t;

  // True when the free credit pool can absorb a burst of 'len' words.
  function automatic logic credit_covers(input int unsigned credit, input int unsigned len);
    return credit >= len;
  endfunction

endpackage

// File: rtl/credit_engine_fifo.sv
// credit_engine_fifo: synchronous first-word-fall-through FIFO with word
// count and registered one-cycle overflow/underflow pulses.
module credit_engine_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_wr_en,
  input  logic [DATA_W-1:0]                i_wr_data,
  input  logic                             i_rd_en,
  output logic [DATA_W-1:0]                o_rd_data,
  output logic                             o_full,
  output logic                             o_empty,
  output logic                             o_overflow,
  output logic                             o_underflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH+1);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_do_rd;
  logic              w_do_wr;

  assign o_full      = (r_count == CW'(FIFO_DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;
  assign o_rd_data   = r_mem[r_rptr];
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

  // A full FIFO still accepts a write when a pop frees the head slot the same cycle.
  assign w_do_rd = i_rd_en & ~o_empty;
  assign w_do_wr = i_wr_en & (~o_full | w_do_rd);

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wr_data;
  end

  // Pointers, occupancy and error pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + AW'(1);
      if (w_do_rd) r_rptr <= r_rptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_overflow  <= i_wr_en & ~w_do_wr;
      r_underflow <= i_rd_en & o_empty;
    end
  end

endmodule

// File: rtl/credit_engine.sv
// credit_engine: ap_start/ap_done driven transaction engine. Looks up a
// {base,len} descriptor, waits until free credit covers len, then bursts len
// data-memory reads into the output FIFO.
// Optional build macro CREDIT_ENGINE_STAT_EN adds saturating transaction and
// credit-stall counters (stat_txn_cnt, stat_stall_cnt).
module credit_engine
  import credit_engine_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DPTR_W     = 8,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CW        = $clog2(FIFO_DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    ap_start,
  output logic                    ap_ready,
  output logic                    ap_done,
  output logic                    ap_err,
  input  logic [ADDR_W-1:0]       addr,
  output logic                    desc_rd,
  output logic [ADDR_W-1:0]       desc_addr,
  input  logic [DPTR_W+LEN_W-1:0] desc_q,
  output logic                    data_rd,
  output logic [DPTR_W-1:0]       data_addr,
  input  logic [DATA_W-1:0]       data_q,
  input  logic                    fifo_rd_en,
  output logic [DATA_W-1:0]       fifo_dout,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    fifo_overflow,
  output logic                    fifo_underflow,
  output logic [CW-1:0]           fifo_data_count,
  output logic [CW-1:0]           credit_cnt
`ifdef CREDIT_ENGINE_STAT_EN
  ,
  output logic [15:0]             stat_txn_cnt,
  output logic [15:0]             stat_stall_cnt
`endif
);

  // Descriptor layout lives here because its field widths follow the parameters.
  typedef struct packed {
    logic [DPTR_W-1:0] base;
    logic [LEN_W-1:0]  len;
  } desc_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  desc_t             r_desc;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W-1:0]  r_wr_cnt;
  logic              r_err;
  logic              r_push;
  logic [CW-1:0]     r_credit;
  logic              w_len_zero;
  logic              w_len_big;
  logic              w_fits;
  logic              w_reserve;
  logic              w_pop;

  assign w_len_zero = (r_desc.len == '0);
  assign w_len_big  = (32'(r_desc.len) > FIFO_DEPTH);
  assign w_fits     = credit_covers(32'(r_credit), 32'(r_desc.len));
  assign w_pop      = fifo_rd_en & ~fifo_empty;

  assign desc_addr  = r_addr;
  assign data_addr  = r_desc.base + DPTR_W'(r_idx);
  assign credit_cnt = r_credit;
  assign ap_err     = (r_state == DONE) & r_err;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    ap_ready    = 1'b0;
    ap_done     = 1'b0;
    desc_rd     = 1'b0;
    data_rd     = 1'b0;
    w_reserve   = 1'b0;
    case (r_state)
      IDLE: begin
        ap_ready = 1'b1;
        if (ap_start) w_state_nxt = RD_DESC;
      end
      RD_DESC: begin
        desc_rd     = 1'b1;
        w_state_nxt = WAIT_DESC;
      end
      WAIT_DESC: w_state_nxt = CHECK;
      CHECK: begin
        if (w_len_zero || w_len_big) begin
          w_state_nxt = DONE;
        end else if (w_fits) begin
          w_reserve   = 1'b1;
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        data_rd = 1'b1;
        if (r_idx == r_desc.len - LEN_W'(1)) w_state_nxt = DRAIN;
      end
      // Leave only once the write counter has registered the final push.
      DRAIN: begin
        if (r_wr_cnt == r_desc.len) w_state_nxt = DONE;
      end
      DONE: begin
        ap_done     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Transaction datapath: address/descriptor capture, burst index, push pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_desc   <= '0;
      r_idx    <= '0;
      r_wr_cnt <= '0;
      r_err    <= 1'b0;
      r_push   <= 1'b0;
    end else begin
      if (r_state == IDLE && ap_start) r_addr <= addr;
      if (r_state == WAIT_DESC)        r_desc <= desc_t'(desc_q);
      if (r_state == CHECK) begin
        r_err    <= w_len_big;
        r_idx    <= '0;
        r_wr_cnt <= '0;
      end
      if (r_state == BURST) r_idx <= r_idx + LEN_W'(1);
      if (r_push)           r_wr_cnt <= r_wr_cnt + LEN_W'(1);
      r_push <= data_rd;
    end
  end

  // Free-credit pool: reservation on CHECK pass and pop return net together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_credit <= CW'(FIFO_DEPTH);
    else r_credit <= r_credit - (w_reserve ? CW'(r_desc.len) : '0) + (w_pop ? CW'(1) : '0);
  end

  credit_engine_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (reset_n),
    .i_wr_en     (r_push),
    .i_wr_data   (data_q),
    .i_rd_en     (fifo_rd_en),
    .o_rd_data   (fifo_dout),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_overflow  (fifo_overflow),
    .o_underflow (fifo_underflow),
    .o_count     (fifo_data_count)
  );

`ifdef CREDIT_ENGINE_STAT_EN
  logic w_stall;
  assign w_stall = (r_state == CHECK) & ~w_len_zero & ~w_len_big & ~w_fits;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_txn_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (ap_done && stat_txn_cnt != '1)   stat_txn_cnt   <= stat_txn_cnt + 16'd1;
      if (w_stall && stat_stall_cnt != '1) stat_stall_cnt <= stat_stall_cnt + 16'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
